proc_datapath: RTL and testbench

Datapath stage directly downstream of the processor control unit. It consumes the control unit's one-hot bus-select (MUXLINE), register load enables (REGSELECTORS) and ADDSUB. It holds general registers R0–R7, accumulator A and result register G, plus a 10-source shared bus and an add/sub unit. It exposes the bus, status flags and a debug read port to the board top level.

---
 rtl/proc_pkg.sv | 30 +++
 rtl/proc_datapath_addsub.sv | 33 +++
 rtl/proc_datapath.sv | 103 ++++++++++
 tb/tb_proc_datapath.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared datapath/control-unit constants for the processor.
// Bus-select, load-enable indices and add/sub encoding.
package proc_pkg;

  localparam int MUX_W   = 10;
  localparam int MUX_DIN = 9;
  localparam int MUX_G   = 8;

  localparam int SEL_G   = 9;
  localparam int SEL_A   = 8;

  localparam logic ADDSUB_ADD = 1'b1;
  localparam logic ADDSUB_SUB = 1'b0;

  localparam int NUM_GPR = 8;

  typedef struct packed {
    logic z;
    logic c;
    logic v;
  } flags_t;

  // More than one select bit set means a bus fight.
  function automatic logic multi_hot(
    input logic [MUX_W-1:0] v
  );
    return (v & (v - MUX_W'(1))) != '0;
  endfunction

endpackage

// File: rtl/proc_datapath_addsub.sv
// Combinational add/sub for the datapath ALU.
// Subtract is A + ~B + 1, so C=1 means no borrow.
module proc_addsub
  import proc_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             addsub_i,
  output logic [WIDTH-1:0] res_o,
  output logic             c_o,
  output logic             v_o,
  output logic             z_o
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             cin;

  // Invert the operand and inject carry-in for subtraction.
  always_comb begin
    cin   = (addsub_i == ADDSUB_SUB);
    b_eff = cin ? ~b_i : b_i;
    sum   = {1'b0, a_i} + {1'b0, b_eff} + (WIDTH+1)'(cin);
    res_o = sum[WIDTH-1:0];
    c_o   = sum[WIDTH];
    v_o   = (a_i[WIDTH-1] == b_eff[WIDTH-1]) &&
            (res_o[WIDTH-1] != a_i[WIDTH-1]);
    z_o   = (res_o == '0);
  end

endmodule

// File: rtl/proc_datapath.sv
// Processor datapath: R0-R7, A, G, shared bus, add/sub, flags.
// A bus conflict suppresses all writes and sets sticky BUSERR.
module proc_datapath
  import proc_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [WIDTH-1:0] DIN,
  input  logic [MUX_W-1:0] MUXLINE,
  input  logic [MUX_W-1:0] REGSELECTORS,
  input  logic             ADDSUB,
  output logic [WIDTH-1:0] BUS,
  output logic             FLAG_Z,
  output logic             FLAG_C,
  output logic             FLAG_V,
  output logic             BUSERR,
  input  logic [2:0]       DBG_SEL,
  output logic [WIDTH-1:0] DBG_DATA
);

  logic [WIDTH-1:0] r_q [NUM_GPR];
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] g_q;
  flags_t           flags_q;
  logic             buserr_q;

  logic             conflict;
  logic [MUX_W-1:0] we;
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] alu_res;
  flags_t           alu_flags;

  assign conflict = multi_hot(MUXLINE);
  assign we       = conflict ? '0 : REGSELECTORS;

  // One-hot bus mux; idle or conflicting selects drive zero.
  always_comb begin
    bus = '0;
    if (!conflict) begin
      if (MUXLINE[MUX_DIN]) bus = DIN;
      if (MUXLINE[MUX_G])   bus = g_q;
      for (int i = 0; i < NUM_GPR; i++) begin
        if (MUXLINE[i]) bus = r_q[i];
      end
    end
  end

  proc_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a_i      (a_q),
    .b_i      (bus),
    .addsub_i (ADDSUB),
    .res_o    (alu_res),
    .c_o      (alu_flags.c),
    .v_o      (alu_flags.v),
    .z_o      (alu_flags.z)
  );

  // General registers load the bus on their enable.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < NUM_GPR; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_GPR; i++) begin
        if (we[i]) r_q[i] <= bus;
      end
    end
  end

  // A, G and flags; G uses the pre-edge A value.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      a_q     <= '0;
      g_q     <= '0;
      flags_q <= '0;
    end else begin
      if (we[SEL_A]) a_q <= bus;
      if (we[SEL_G]) begin
        g_q     <= alu_res;
        flags_q <= alu_flags;
      end
    end
  end

  // Sticky conflict flag, cleared only by reset.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) buserr_q <= 1'b0;
    else if (conflict) buserr_q <= 1'b1;
  end

  assign BUS      = bus;
  assign FLAG_Z   = flags_q.z;
  assign FLAG_C   = flags_q.c;
  assign FLAG_V   = flags_q.v;
  assign BUSERR   = buserr_q;
  assign DBG_DATA = r_q[DBG_SEL];

endmodule

// File: tb/tb_proc_datapath.sv
// Self-checking bench for proc_datapath.
// Directed plan steps plus random ops against a reference model.
`timescale 1ns/100ps
module tb_proc_datapath;

  localparam int W = 9;
  localparam int M = 512;

  logic         clk = 1'b0;
  logic         rstn;
  logic [W-1:0] din;
  logic [9:0]   mux;
  logic [9:0]   sel;
  logic         addsub;
  logic [W-1:0] bus;
  logic         fz, fc, fv, berr;
  logic [2:0]   dsel;
  logic [W-1:0] ddata;

  int passed = 0;
  int total  = 0;

  int mr [8];
  int ma, mg;
  bit mz, mc, mv, mb;

  always #20 clk = ~clk;

  proc_datapath #(.WIDTH(W)) dut (
    .CLK          (clk),
    .RESETN       (rstn),
    .DIN          (din),
    .MUXLINE      (mux),
    .REGSELECTORS (sel),
    .ADDSUB       (addsub),
    .BUS          (bus),
    .FLAG_Z       (fz),
    .FLAG_C       (fc),
    .FLAG_V       (fv),
    .BUSERR       (berr),
    .DBG_SEL      (dsel),
    .DBG_DATA     (ddata)
  );

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mr[i] = 0;
    ma = 0; mg = 0;
    mz = 0; mc = 0; mv = 0; mb = 0;
  endtask

  function automatic int sgn(input int x);
    return (x >= M/2) ? x - M : x;
  endfunction

  function automatic int mbus(input int d, input logic [9:0] m);
    if ($countones(m) != 1) return 0;
    if (m[9]) return d;
    if (m[8]) return mg;
    for (int i = 0; i < 8; i++) if (m[i]) return mr[i];
    return 0;
  endfunction

  // Full state compare: G via bus, R via debug port, flags.
  task automatic verify(input string tag);
    sel = '0;
    mux = 10'h100;
    #1 chk({tag, "_G"}, bus, W'(mg));
    for (int i = 0; i < 8; i++) begin
      dsel = 3'(i);
      #1 chk($sformatf("%s_R%0d", tag, i), ddata, W'(mr[i]));
    end
    chk({tag, "_Z"}, W'(fz), W'(mz));
    chk({tag, "_C"}, W'(fc), W'(mc));
    chk({tag, "_V"}, W'(fv), W'(mv));
    chk({tag, "_BERR"}, W'(berr), W'(mb));
  endtask

  task automatic step(input string tag, input int d,
                      input logic [9:0] m, input logic [9:0] s,
                      input logic as);
    int b, res, sr;
    @(negedge clk);
    din = W'(d); mux = m; sel = s; addsub = as;
    b = mbus(d, m);
    #1 chk({tag, "_bus"}, bus, W'(b));
    if ($countones(m) > 1) begin
      mb = 1;
    end else begin
      if (s[9]) begin
        if (as) begin
          res = ma + b;
          mc  = (res >= M);
          sr  = sgn(ma) + sgn(b);
        end else begin
          res = ma - b;
          mc  = (ma >= b);
          sr  = sgn(ma) - sgn(b);
        end
        mg = (res + M) % M;
        mz = (mg == 0);
        mv = (sr < -M/2) || (sr >= M/2);
      end
      for (int i = 0; i < 8; i++) if (s[i]) mr[i] = b;
      if (s[8]) ma = b;
    end
    @(posedge clk);
    #1 verify(tag);
  endtask

  task automatic rd(input string tag, input int idx, input int exp);
    dsel = 3'(idx);
    #1 chk(tag, ddata, W'(exp));
  endtask

  initial begin
    logic [9:0] rm, rs;
    rstn = 1'b0; din = '0; mux = '0; sel = '0;
    addsub = 1'b0; dsel = '0;
    model_reset();
    #15;
    verify("rst");
    rstn = 1'b1;

    // 1: DIN into R1
    step("t1", 9'h0A5, 10'h200, 10'h002, 1'b1);
    rd("t1_r1", 1, 9'h0A5);
    // 2: R1 into R3
    step("t2", 0, 10'h002, 10'h008, 1'b1);
    rd("t2_r3", 3, 9'h0A5);
    // 3: 5 + 3
    step("t3a", 5, 10'h200, 10'h001, 1'b1);
    step("t3b", 3, 10'h200, 10'h002, 1'b1);
    step("t3c", 0, 10'h001, 10'h100, 1'b1);
    step("t3d", 0, 10'h002, 10'h200, 1'b1);
    step("t3e", 0, 10'h100, 10'h001, 1'b1);
    rd("t3_r0", 0, 8);
    chk("t3_z", W'(fz), 0);
    chk("t3_c", W'(fc), 0);
    chk("t3_v", W'(fv), 0);
    // 4: 8-8, then 2-3
    step("t4a", 0, 10'h001, 10'h100, 1'b0);
    step("t4b", 0, 10'h001, 10'h200, 1'b0);
    chk("t4_z", W'(fz), 1);
    chk("t4_c", W'(fc), 1);
    step("t4c", 2, 10'h200, 10'h100, 1'b0);
    step("t4d", 3, 10'h200, 10'h200, 1'b0);
    step("t4e", 0, 10'h100, 10'h010, 1'b0);
    rd("t4_r4", 4, 9'h1FF);
    chk("t4_c2", W'(fc), 0);
    chk("t4_z2", W'(fz), 0);
    // 5: wrap, signed overflow, simultaneous A/G
    step("t5a", 9'h1FF, 10'h200, 10'h100, 1'b1);
    step("t5b", 1, 10'h200, 10'h200, 1'b1);
    chk("t5_z", W'(fz), 1);
    chk("t5_c", W'(fc), 1);
    chk("t5_v", W'(fv), 0);
    step("t5c", 9'h0FF, 10'h200, 10'h100, 1'b1);
    step("t5d", 1, 10'h200, 10'h200, 1'b1);
    chk("t5_v2", W'(fv), 1);
    chk("t5_c2", W'(fc), 0);
    step("t5e", 1, 10'h200, 10'h100, 1'b1);
    step("t5f", 4, 10'h200, 10'h300, 1'b1);
    step("t5g", 0, 10'h200, 10'h200, 1'b1);
    chk("t5_ga", bus, 9'h004);

    // random ops, mostly one-hot selects
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0:       rm = '0;
        1:       rm = 10'(1 << $urandom_range(0, 9)) |
                      10'(1 << $urandom_range(0, 9));
        default: rm = 10'(1 << $urandom_range(0, 9));
      endcase
      rs = 10'($urandom_range(0, 1023)) &
           10'($urandom_range(0, 1023));
      step($sformatf("rnd%0d", n), $urandom_range(0, M-1),
           rm, rs, 1'($urandom_range(0, 1)));
    end

    // 6: conflict, sticky BUSERR, async reset mid-cycle
    @(negedge clk);
    rstn = 1'b0;
    model_reset();
    #1 verify("r6");
    rstn = 1'b1;
    step("t6p", 9'h033, 10'h200, 10'h004, 1'b1);
    step("t6a", 9'h111, 10'h003, 10'h004, 1'b1);
    rd("t6_r2", 2, 9'h033);
    chk("t6_berr", W'(berr), 1);
    step("t6b", 7, 10'h200, 10'h020, 1'b1);
    step("t6c", 0, 10'h000, 10'h000, 1'b1);
    chk("t6_sticky", W'(berr), 1);
    step("t6d", 9, 10'h200, 10'h100, 1'b1);
    step("t6e", 2, 10'h200, 10'h200, 1'b1);
    @(posedge clk);
    #7 rstn = 1'b0;
    model_reset();
    #1 verify("t6r");
    chk("t6r_berr", W'(berr), 0);
    rstn = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
